// File: rtl/key_pkg.sv
// Shared definitions for the key gesture classifier: state codes, key polarity,
// event bundle and the cycles-per-millisecond helper.
package key_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE      = 3'd0;
    localparam state_t PRESS1    = 3'd1;
    localparam state_t WAIT2     = 3'd2;
    localparam state_t PRESS2    = 3'd3;
    localparam state_t LONG_HOLD = 3'd4;

    // Debounced key is active-low.
    localparam logic KEY_PRESSED = 1'b0;

    typedef struct packed {
        logic short_press;
        logic long_press;
        logic double_click;
    } key_evt_t;

    function automatic int unsigned cyc_per_ms(input int unsigned freq_mhz);
        return freq_mhz * 1000;
    endfunction

endpackage

// File: rtl/key_event_classifier_if.sv
// Key level in, classified gesture pulses out.
interface key_event_classifier_if;

    logic key_db;
    logic key_pressed;
    logic short_press;
    logic long_press;
    logic double_click;

    modport master (
        output key_db,
        input  key_pressed, short_press, long_press, double_click
    );

    modport slave (
        input  key_db,
        output key_pressed, short_press, long_press, double_click
    );

endinterface

// File: rtl/ms_tick_gen.sv
// Cycle prescaler producing a one-cycle ms_tick and a saturating ms counter;
// clr restarts both so a window is timed exactly from the clearing edge.
module ms_tick_gen #(
    parameter int unsigned CYC_PER_MS = 50000,
    parameter int unsigned MS_W       = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    output logic            ms_tick,
    output logic [MS_W-1:0] ms_cnt
);

    localparam int unsigned CYC_W = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
    localparam logic [CYC_W-1:0] CYC_MAX = CYC_W'(CYC_PER_MS - 1);

    logic [CYC_W-1:0] cyc;

    assign ms_tick = (cyc == CYC_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc    <= '0;
            ms_cnt <= '0;
        end else if (clr) begin
            cyc    <= '0;
            ms_cnt <= '0;
        end else begin
            cyc <= ms_tick ? '0 : cyc + 1'b1;
            if (ms_tick && (ms_cnt != '1))
                ms_cnt <= ms_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/key_event_classifier.sv
// Classifies debounced key gestures into short press, long press and double
// click, each reported as a registered one-cycle pulse.
module key_event_classifier
    import key_pkg::*;
#(
    parameter int unsigned FREQ      = 50,
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned DCLICK_MS = 300,
    parameter int unsigned MS_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    key_event_classifier_if.slave  kif
);

    logic            key_d;
    state_t          state, state_nxt;
    key_evt_t        evt, evt_nxt;
    logic            ms_tick;
    logic [MS_W-1:0] ms_cnt;
    logic            press, rel, long_to, dc_to, clr;

    assign press   = (key_d != KEY_PRESSED) && (kif.key_db == KEY_PRESSED);
    assign rel     = (key_d == KEY_PRESSED) && (kif.key_db != KEY_PRESSED);
    assign long_to = ms_tick && (ms_cnt == MS_W'(LONG_MS - 1));
    assign dc_to   = ms_tick && (ms_cnt == MS_W'(DCLICK_MS - 1));
    assign clr     = (state_nxt != state);

    ms_tick_gen #(
        .CYC_PER_MS (cyc_per_ms(FREQ)),
        .MS_W       (MS_W)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .ms_tick (ms_tick),
        .ms_cnt  (ms_cnt)
    );

    // key_d resets released so a key held through reset counts as a new press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_d <= 1'b1;
            state <= IDLE;
            evt   <= '0;
        end else begin
            key_d <= kif.key_db;
            state <= state_nxt;
            evt   <= evt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (press) state_nxt = PRESS1;
            PRESS1:    if (long_to) state_nxt = LONG_HOLD;
                       else if (rel) state_nxt = WAIT2;
            WAIT2:     if (press) state_nxt = PRESS2;
                       else if (dc_to) state_nxt = IDLE;
            PRESS2:    if (rel) state_nxt = IDLE;
                       else if (long_to) state_nxt = LONG_HOLD;
            // Level test: a release hidden behind a coincident timeout still exits.
            LONG_HOLD: if (kif.key_db != KEY_PRESSED) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        evt_nxt = '0;
        case (state)
            PRESS1:  evt_nxt.long_press   = long_to;
            WAIT2:   evt_nxt.short_press  = !press && dc_to;
            PRESS2:  evt_nxt.double_click = rel || long_to;
            default: evt_nxt = '0;
        endcase
    end

    assign kif.key_pressed  = (key_d == KEY_PRESSED);
    assign kif.short_press  = evt.short_press;
    assign kif.long_press   = evt.long_press;
    assign kif.double_click = evt.double_click;

endmodule

// File: tb/tb_key_event_classifier.sv
// Scoreboard bench: each gesture pushes its expected event and cycle, and a
// negedge monitor pops and compares every pulse the classifier emits.
module tb_key_event_classifier;

    localparam int T_LONG = 10000;
    localparam int T_DC   = 3000;

    localparam int EV_SHORT = 0;
    localparam int EV_LONG  = 1;
    localparam int EV_DBL   = 2;

    typedef struct {
        int     kind;
        longint at;
    } ev_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    longint cyc = 0;
    longint last_edge = 0;
    int     checks = 0;
    int     errors = 0;
    ev_t    sb[$];
    ev_t    e;
    int     kind;
    logic [2:0] pulses;

    key_event_classifier_if kif();

    key_event_classifier #(
        .FREQ      (1),
        .LONG_MS   (10),
        .DCLICK_MS (3),
        .MS_W      (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (kif)
    );

    always #5 clk = ~clk;

    // cyc equals the index of the most recent rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // A value set here is first sampled by the next rising edge.
    task automatic set_key(input logic v);
        kif.key_db = v;
        last_edge  = cyc + 1;
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input longint at);
        ev_t x;
        x.kind = k;
        x.at   = at;
        sb.push_back(x);
    endtask

    assign pulses = {kif.long_press, kif.short_press, kif.double_click};

    always @(negedge clk) begin
        if (rst_n && pulses != 3'b000) begin
            chk("onehot", 64'($countones(pulses)), 64'd1);
            kind = kif.short_press ? EV_SHORT : (kif.long_press ? EV_LONG : EV_DBL);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 64'(pulses), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("event_kind", 64'(kind), 64'(e.kind));
                chk("event_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    initial begin
        longint r;
        kif.key_db = 1'b1;
        rst_n = 1'b0;
        hold(3);
        chk("rst_key_pressed", 64'(kif.key_pressed), 64'd0);
        chk("rst_short", 64'(kif.short_press), 64'd0);
        chk("rst_long", 64'(kif.long_press), 64'd0);
        chk("rst_dbl", 64'(kif.double_click), 64'd0);
        rst_n = 1'b1;
        hold(2);

        // Short press: 2000 low, then released.
        set_key(1'b0); hold(2000);
        set_key(1'b1); push(EV_SHORT, last_edge + T_DC);
        hold(4000);

        // Long press: 15000 low.
        set_key(1'b0); push(EV_LONG, last_edge + T_LONG);
        hold(5000);
        chk("long_key_pressed_mid", 64'(kif.key_pressed), 64'd1);
        hold(10000);
        chk("long_key_pressed_end", 64'(kif.key_pressed), 64'd1);
        set_key(1'b1); hold(4000);
        chk("long_key_released", 64'(kif.key_pressed), 64'd0);

        // Double click: low 1000, high 1500, low 1000, high.
        set_key(1'b0); hold(1000);
        set_key(1'b1); hold(1500);
        set_key(1'b0); hold(1000);
        set_key(1'b1); push(EV_DBL, last_edge);
        hold(4000);

        // Second press sampled on the DCLICK timeout edge.
        set_key(1'b0); hold(500);
        set_key(1'b1); hold(T_DC);
        set_key(1'b0); hold(500);
        set_key(1'b1); push(EV_DBL, last_edge);
        hold(4000);

        // Second press one cycle late: short, then a fresh PRESS1.
        set_key(1'b0); hold(500);
        set_key(1'b1); r = last_edge; push(EV_SHORT, r + T_DC);
        hold(T_DC + 1);
        set_key(1'b0); hold(500);
        set_key(1'b1); push(EV_SHORT, last_edge + T_DC);
        hold(4000);

        // Release coincident with the long timeout; a later short press proves IDLE.
        set_key(1'b0); push(EV_LONG, last_edge + T_LONG);
        hold(T_LONG);
        set_key(1'b1); hold(4000);
        set_key(1'b0); hold(200);
        set_key(1'b1); push(EV_SHORT, last_edge + T_DC);
        hold(3500);

        // Reset mid-PRESS1, key still held at reset release.
        set_key(1'b0); hold(5000);
        chk("pre_rst_key_pressed", 64'(kif.key_pressed), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_key_pressed", 64'(kif.key_pressed), 64'd0);
        chk("async_rst_pulses", 64'(pulses), 64'd0);
        hold(5);
        rst_n = 1'b1;
        push(EV_LONG, cyc + 1 + T_LONG);
        hold(T_LONG + 500);
        set_key(1'b1); hold(3000);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_event_classifier.md
Name: key_event_classifier

Overview:
- Sits directly downstream of the key debouncer.
- Consumes the clean, debounced key level (active-low, idle high) and classifies each gesture into one of three events: short press, long press or double click.
- Each event is reported as a one-clock pulse to the application logic (LED control, menu FSMs).
- A shared millisecond tick sub-module provides all timing.

Parameters:
- FREQ, 50, clock frequency in MHz.
- LONG_MS, 1000, hold time in ms that classifies a press as long.
- DCLICK_MS, 300, maximum release-to-second-press gap in ms for a double click.
- MS_W, 16, width of the millisecond counter; must hold max(LONG_MS, DCLICK_MS).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- key_db  in  1  debounced key level; 0 = pressed, 1 = released.
- key_pressed  out  1  registered level, 1 while key_db was 0 on the last edge.
- short_press  out  1  one-cycle pulse: single press released before LONG_MS, with no second press within DCLICK_MS.
- long_press  out  1  one-cycle pulse: first press held for LONG_MS.
- double_click  out  1  one-cycle pulse: second press within the DCLICK_MS window.

Behaviour:
- Reset (async, any time, including mid-gesture):
  - state = IDLE; all counters = 0; all outputs = 0.
  - Edge register key_d = 1, so a key already held at reset release is treated as a new press.
- Edge detect, all evaluated with key_d = key_db delayed one clock:
  - press = key_d & ~key_db.
  - release = ~key_d & key_db.
  - key_pressed = ~key_d.
- Timer:
  - Cycle counter runs 0 .. FREQ*1000-1; ms_tick is high when the counter is at its maximum.
  - ms_cnt increments on ms_tick and saturates at 2^MS_W-1.
  - Both counters clear synchronously on every state transition, so each window is timed exactly from state entry.
  - T_LONG = LONG_MS*1000*FREQ cycles; T_DC = DCLICK_MS*1000*FREQ cycles.
- State machine (transitions and output pulses registered on the same edge):
  - IDLE: press -> PRESS1.
  - PRESS1:
    - Timeout (ms_cnt==LONG_MS-1 && ms_tick) -> LONG_HOLD, long_press=1.
    - Else release -> WAIT2.
    - Timeout wins over a coincident release.
  - WAIT2:
    - press -> PRESS2.
    - Else timeout (ms_cnt==DCLICK_MS-1 && ms_tick) -> IDLE, short_press=1.
    - press wins over a coincident timeout.
  - PRESS2:
    - release -> IDLE, double_click=1.
    - Timeout at LONG_MS -> LONG_HOLD, double_click=1.
    - long_press is never issued from PRESS2.
  - LONG_HOLD: key_db==1 (level, not edge) -> IDLE. Because this test is level-based, a release swallowed by a coincident event is never lost.
- Output pulses are exactly 1 cycle wide; at most one pulse per cycle; the pulse outputs are mutually exclusive.
- Latencies, measured from edge E0, where E0 is the first edge that samples the triggering key_db value:
  - long_press is high in the cycle after edge E0+T_LONG.
  - short_press is high in the cycle after edge E1+T_DC, where E1 is the release-sampling edge.
- A single press always costs T_DC of extra latency before short_press; this is accepted.
- key_db glitches are not filtered here; upstream guarantees stability.

Decomposition:
- Shared package key_pkg holds:
  - state encoding localparams: IDLE=0, PRESS1=1, WAIT2=2, PRESS2=3, LONG_HOLD=4, 3-bit;
  - KEY_PRESSED=1'b0 level constant;
  - the cycles-per-ms expression FREQ*1000.
- One sub-module, ms_tick_gen:
  - Ports: clk, rst_n, clr, ms_tick, ms_cnt.
  - Contains the cycle prescaler and the saturating ms counter.
  - Reusable by other timed UI blocks.

Test Plan (FREQ=1, LONG_MS=10, DCLICK_MS=3, so 1 ms = 1000 cycles):
- Short press:
  - Stimulus: key_db low for 2000 cycles, then high.
  - Required: exactly one short_press pulse, in the cycle after release edge + 3000; long_press and double_click stay 0.
- Long press:
  - Stimulus: key_db low for 15000 cycles.
  - Required: long_press pulses once in the cycle after press edge + 10000; key_pressed=1 throughout; release gives no further pulse and returns to IDLE.
- Double click:
  - Stimulus: low 1000, high 1500, low 1000, high.
  - Required: one double_click pulse in the cycle after the second release edge; no short_press.
- Window boundaries:
  - Second press arriving on the same edge as the DCLICK timeout -> double_click path taken.
  - Second press arriving 1 cycle after that edge -> short_press, then the new press starts a fresh PRESS1.
- PRESS1 boundary: release coincident with the T_LONG timeout -> long_press=1, then IDLE on the following edge via the LONG_HOLD level check.
- Reset:
  - rst_n asserted mid-PRESS1 at cycle 5000 -> all outputs 0 immediately (async).
  - Key still held at rst_n release -> a new PRESS1 starts; long_press fires 10000 cycles later.
